// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the job-assignment solver front end.
package jam_pkg;

  localparam int N         = 8;
  localparam int IDX_W     = 3;
  localparam int COST_W    = 7;
  localparam int NN        = N * N;
  localparam int CNT_W     = $clog2(NN);
  localparam int MINCOST_W = 10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    SERVE = 2'd2
  } state_e;

  // Row-major cell address: worker selects the row, job the column.
  function automatic logic [CNT_W-1:0] cell_addr(input logic [IDX_W-1:0] w,
                                                 input logic [IDX_W-1:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/cost_regfile.sv
// 64-entry cost store: one synchronous write port, one combinational read port, no reset.
module cost_regfile
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [CNT_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [CNT_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem_q [NN];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_loader.sv
// Streams an 8x8 cost matrix from the host, then serves solver lookups until the
// solver reports a result, issuing a one-cycle restart pulse between the two.
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic              in_last,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              sol_start,
  input  logic              sol_valid,
  output logic              load_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              xfer;
  logic [COST_W-1:0] rdata;

  assign xfer = in_valid & in_ready;

  cost_regfile u_regfile (
    .CLK   (CLK),
    .we    (xfer),
    .waddr (cnt_q),
    .wdata (in_data),
    .raddr (cell_addr(W, J)),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (in_last && (cnt_q == LAST_BEAT)) begin
            state_d = START;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else if (in_last || (cnt_q == LAST_BEAT)) begin
            // Early last or missing last: drop the matrix, never wrap into a load.
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START:   state_d = SERVE;
      SERVE:   if (sol_valid) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    start_d = (state_d == START);
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q == START) || (state_q == SERVE);
    sol_start = start_q;
    load_err  = err_q;
    // Stale matrix contents never leak outside the serve window.
    Cost      = (state_q == SERVE) ? rdata : '0;
  end

endmodule

// File: doc/jam_cost_loader.md
Name: jam_cost_loader

Overview:
- Upstream stage of the job-assignment solver. Accepts an 8x8 cost matrix streamed from the host over a valid/ready handshake and stores it in an internal register array.
- Then serves the solver's worker/job lookups (W, J) with a zero-latency combinational Cost read.
- Sequences matrices: issues a one-cycle solver start pulse after a complete load, and accepts the next matrix only after the solver reports Valid.

Parameters:
- N, 8, matrix dimension (workers = jobs = N).
- IDX_W, 3, width of the W/J index (log2 N).
- COST_W, 7, width of one cost entry.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  host beat valid.
- in_ready  out  1  loader accepts a beat this cycle.
- in_data  in  COST_W  cost entry, row-major order (beat k = worker k/N, job k%N).
- in_last  in  1  host marks the final beat of a matrix.
- W  in  IDX_W  worker index from the solver.
- J  in  IDX_W  job index from the solver.
- Cost  out  COST_W  cost[W][J] while in SERVE, else 0.
- sol_start  out  1  one-cycle pulse; solver restarts on it (drives the solver's active-high restart).
- sol_valid  in  1  solver result valid (end of search).
- load_err  out  1  sticky; set on a malformed matrix, cleared by the next good load.
- busy  out  1  high in START or SERVE.

Behaviour:
- Reset (RST_N low, async): state=LOAD, beat count=0, in_ready=1, sol_start=0, load_err=0, busy=0, Cost=0. Array contents are don't-care; no output exposes them before a complete load.
- Handshake: a beat transfers on a rising edge with in_valid & in_ready. in_ready=1 only in LOAD. in_data and in_last are sampled only on a transfer.
- Beat write: beat k writes mem[k]. Beat count is 6 bits, counting 0..N*N-1 (0..63), and increments per transfer.
- Well-formed matrix: in_last coincides with beat count = N*N-1. On that beat: write the entry, count<=0, load_err<=0, next state START.
- in_last early (count < 63): discard the matrix, count<=0, load_err<=1, stay in LOAD. Entries already written are overwritten by the next matrix.
- Beat 63 without in_last: treated as malformed. load_err<=1, count<=0, stay in LOAD. There is no wrap into a valid load.
- States:
  - LOAD: accept beats as above.
  - START: one cycle. sol_start=1, busy=1, then SERVE.
  - SERVE: busy=1, in_ready=0. Cost = mem[W*N+J] combinationally, in the same cycle as W/J (the solver accumulates Cost in the cycle it presents W/J). On sol_valid=1, go to LOAD next cycle.
- sol_valid outside SERVE: ignored.
- sol_start: registered output, high exactly one cycle. Never asserted in LOAD.
- Cost outside SERVE: forced to 0, so stray solver reads cannot leak stale data.
- Reset mid-load or mid-serve: returns to LOAD immediately (async). A partial matrix is lost; the host must resend from beat 0.
- Host backpressure: in_valid may drop between beats; the count holds. Throughput is 1 beat/cycle when in_valid is held high, so a full load takes 64 cycles plus 1 START cycle.

Decomposition:
- Shared package jam_pkg holds:
  - N, IDX_W, COST_W, and the derived N*N and count width.
  - The state encoding (LOAD, START, SERVE).
  - The 10-bit MinCost width constant shared with the solver.
- Sub-module cost_regfile:
  - 64xCOST_W register array with one synchronous write port (we, waddr[5:0], wdata) and one combinational read port (raddr[5:0]).
  - No reset on the array.
- Top: FSM, beat counter, handshake, output gating.

Test Plan:
- Reset then stream a matrix with cost[w][j]=w*8+j, in_valid held high, in_last on beat 63. Required: in_ready drops after beat 63; sol_start is high for exactly 1 cycle, 1 cycle later; in SERVE, W=5/J=3 gives Cost=43 in the same cycle.
- in_last asserted on beat 10. Required: load_err=1, no sol_start, in_ready stays 1. Then a full good matrix: load_err clears on its beat 63 and sol_start pulses.
- Random in_valid gaps (≈50% duty) across a full load. Required: every entry is read back correctly in SERVE, and the host sees no transfer while in_ready=0.
- In SERVE, assert sol_valid for 1 cycle. Required: next cycle in LOAD, in_ready=1, busy=0, Cost=0 for any W/J. Also with W=7, J=7, and in_valid=1 held during SERVE: no beat is consumed.
- Pull RST_N low mid-load (beat 30) and mid-serve. Required: outputs return to reset values asynchronously; after release, a full 64-beat load is needed before sol_start.
- Stream 64 beats with in_last never asserted. Required: load_err=1, count returns to 0, no sol_start.
